if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 19 +
 rtl/if_stage_icache.sv | 52 +++++
 rtl/if_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared widths, constants and FSM encoding for the instruction fetch stage and its cache.
package if_stage_pkg;

    localparam int unsigned StallBusW  = 6;
    localparam int unsigned InstAddrW  = 32;
    localparam int unsigned InstW      = 32;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    localparam int unsigned CacheDepth = 16;
    localparam int unsigned IndexW     = 4;
    localparam int unsigned TagW       = InstAddrW - IndexW - 2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFetch   = 2'd1,
        StDiscard = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_stage_icache.sv
// Direct-mapped instruction cache: 16 one-word lines, combinational lookup, single fill port.
module if_stage_icache
    import if_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [InstAddrW-1:0] lookup_addr,
    output logic                 hit,
    output logic [InstW-1:0]     lookup_data,
    input  logic                 fill_en,
    input  logic [InstAddrW-1:0] fill_addr,
    input  logic [InstW-1:0]     fill_data
);

    logic [TagW-1:0]       tag_mem  [CacheDepth];
    logic [InstW-1:0]      data_mem [CacheDepth];
    logic [CacheDepth-1:0] valid;

    logic [IndexW-1:0] lookup_idx;
    logic [IndexW-1:0] fill_idx;
    logic [TagW-1:0]   lookup_tag;
    logic [TagW-1:0]   fill_tag;
    logic              unused_byte_bits;

    assign lookup_idx = lookup_addr[IndexW+1:2];
    assign lookup_tag = lookup_addr[InstAddrW-1:IndexW+2];
    assign fill_idx   = fill_addr[IndexW+1:2];
    assign fill_tag   = fill_addr[InstAddrW-1:IndexW+2];

    // Addresses are word-aligned; the byte offset carries no information.
    assign unused_byte_bits = ^{lookup_addr[1:0], fill_addr[1:0]};

    // Reads see the arrays before this cycle's fill lands.
    assign hit         = valid[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign lookup_data = data_mem[lookup_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, miss FSM and memory request, backed by if_stage_icache.
module if_stage
    import if_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [StallBusW-1:0] stall_state,
    input  logic                 jump_flag,
    input  logic [InstAddrW-1:0] jump_addr,
    output logic                 mem_req,
    output logic [InstAddrW-1:0] mem_addr,
    input  logic                 mem_ready,
    input  logic [InstW-1:0]     mem_rdata,
    output logic [InstAddrW-1:0] if_pc,
    output logic [InstW-1:0]     if_inst,
    output logic                 if_stall_req
);

    if_state_e            state_q, state_d;
    logic [InstAddrW-1:0] pc_q, pc_d;
    logic [InstAddrW-1:0] mem_addr_q, mem_addr_d;

    logic                 hit;
    logic [InstW-1:0]     hit_data;
    logic                 fill_en;
    logic                 deliver;
    logic [InstW-1:0]     deliver_data;
    logic                 unused_stall_bits;

    // Only the PC hold bit concerns this stage; the rest steer later stages.
    assign unused_stall_bits = ^stall_state[StallBusW-1:1];

    if_stage_icache u_icache (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (pc_q),
        .hit         (hit),
        .lookup_data (hit_data),
        .fill_en     (fill_en),
        .fill_addr   (mem_addr_q),
        .fill_data   (mem_rdata)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        fill_en      = 1'b0;
        deliver      = 1'b0;
        deliver_data = ZeroWord;
        if_stall_req = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    deliver      = !jump_flag;
                    deliver_data = hit_data;
                end else if (!jump_flag) begin
                    state_d      = StFetch;
                    mem_addr_d   = pc_q;
                    if_stall_req = 1'b1;
                end
            end
            StFetch: begin
                if (mem_ready) begin
                    fill_en      = 1'b1;
                    state_d      = StIdle;
                    deliver      = !jump_flag;
                    deliver_data = mem_rdata;
                end else if (jump_flag) begin
                    state_d = StDiscard;
                end else begin
                    if_stall_req = 1'b1;
                end
            end
            StDiscard: begin
                // Returned word is valid memory data, so keep it even though it is dropped.
                if_stall_req = !jump_flag;
                if (mem_ready) begin
                    fill_en = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (jump_flag) begin
            pc_d = jump_addr;
        end else if (deliver && !stall_state[0]) begin
            pc_d = pc_q + 32'd4;
        end

        if (rst) begin
            fill_en      = 1'b0;
            deliver      = 1'b0;
            if_stall_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= ZeroWord;
            mem_addr_q <= ZeroWord;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_req  = (state_q != StIdle);
    assign mem_addr = mem_addr_q;
    assign if_pc    = deliver ? pc_q : ZeroWord;
    assign if_inst  = deliver ? deliver_data : ZeroWord;

endmodule
